// File: rtl/pkg_teclado.sv
// pkg_teclado: shared state enum, key-code constants and digit helper for keypad entry
package pkg_teclado;
  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, DONE} state_t;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  function automatic logic is_digit(input logic [3:0] c);
    return c <= 4'd9;
  endfunction
endpackage

// File: rtl/module_detector_flanco.sv
// module_detector_flanco: one-cycle pulse on a registered 0->1 of in, suppressed until in is first seen low after reset (clk, rst active-low async, in, pulse)
module module_detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic q, p, armed;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q     <= 1'b0;
      p     <= 1'b0;
      armed <= 1'b0;
    end else begin
      q     <= in;
      p     <= q;
      armed <= armed | ~in;
    end
  assign pulse = q & ~p & armed;
endmodule

// File: rtl/module_control_entrada.sv
// module_control_entrada: keypad two-operand BCD entry FSM (clk, rst active-low async, code/valido in; op_a, op_b, display, n_dig, sel_b, listo, done registered out)
module module_control_entrada #(
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            code,
  input  logic                  valido,
  output logic [4*N_DIGITS-1:0] op_a,
  output logic [4*N_DIGITS-1:0] op_b,
  output logic [4*N_DIGITS-1:0] display,
  output logic [2:0]            n_dig,
  output logic                  sel_b,
  output logic                  listo,
  output logic                  done
);
  import pkg_teclado::*;
  localparam int W = 4 * N_DIGITS;
  state_t         state, s_n;
  logic [W-1:0]   a_n, b_n, cur, nxt;
  logic [2:0]     k_n;
  logic           l_n, ev;
  module_detector_flanco u_flanco (
    .clk  (clk),
    .rst  (rst),
    .in   (valido),
    .pulse(ev)
  );
  always_comb begin
    s_n = state;
    a_n = op_a;
    b_n = op_b;
    k_n = n_dig;
    l_n = 1'b0;
    cur = (state == ENTRY_B) ? op_b : op_a;
    nxt = cur;
    if (ev && code == KEY_C) begin
      a_n = '0;
      b_n = '0;
      k_n = 3'd0;
      s_n = ENTRY_A;
    end else if (ev && state == DONE) begin
      if (is_digit(code)) begin
        a_n = W'(code);
        b_n = '0;
        k_n = 3'd1;
        s_n = ENTRY_A;
      end
    end else if (ev) begin
      if (is_digit(code) && n_dig < 3'(N_DIGITS)) begin
        nxt = (cur << 4) | W'(code);
        k_n = n_dig + 3'd1;
      end else if (code == KEY_D && n_dig != 3'd0) begin
        nxt = cur >> 4;
        k_n = n_dig - 3'd1;
      end else if (code == KEY_STAR) begin
        nxt = '0;
        k_n = 3'd0;
      end else if (code == KEY_HASH && n_dig != 3'd0) begin
        k_n = (state == ENTRY_A) ? 3'd0 : n_dig;
        s_n = (state == ENTRY_A) ? ENTRY_B : DONE;
        l_n = state == ENTRY_B;
      end
      if (state == ENTRY_B) b_n = nxt;
      else a_n = nxt;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= ENTRY_A;
      op_a    <= '0;
      op_b    <= '0;
      display <= '0;
      n_dig   <= 3'd0;
      sel_b   <= 1'b0;
      listo   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= s_n;
      op_a    <= a_n;
      op_b    <= b_n;
      display <= (s_n == ENTRY_A) ? a_n : b_n;
      n_dig   <= k_n;
      sel_b   <= s_n != ENTRY_A;
      listo   <= l_n;
      done    <= s_n == DONE;
    end
endmodule

// File: tb/tb_module_control_entrada.sv
// tb_module_control_entrada: directed and random key sequences checked against a digit-queue reference model
module tb_module_control_entrada;
  localparam int N = 3;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   code = 4'h0;
  logic         valido = 1'b0;
  logic [4*N-1:0] op_a, op_b, display;
  logic [2:0]   n_dig;
  logic         sel_b, listo, done;
  int n_checks = 0;
  int n_fail = 0;
  int listo_cnt = 0;
  int exp_listo = 0;
  int mode = 0;
  int qa[$];
  int qb[$];

  module_control_entrada #(.N_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .code(code), .valido(valido),
    .op_a(op_a), .op_b(op_b), .display(display), .n_dig(n_dig),
    .sel_b(sel_b), .listo(listo), .done(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (listo) listo_cnt++;

  function automatic int val(input int q[$]);
    int v = 0;
    foreach (q[i]) v = (v << 4) | q[i];
    return v;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_key(input int k);
    int cur[$];
    if (k == 12) begin
      qa.delete(); qb.delete(); mode = 0;
    end else if (mode == 2) begin
      if (k < 10) begin qa = {k}; qb.delete(); mode = 0; end
    end else begin
      cur = (mode == 1) ? qb : qa;
      if (k < 10) begin
        if (cur.size() < N) cur.push_back(k);
      end else if (k == 13) begin
        if (cur.size() > 0) void'(cur.pop_back());
      end else if (k == 14) begin
        cur.delete();
      end
      if (mode == 1) qb = cur; else qa = cur;
      if (k == 15 && cur.size() > 0) begin
        if (mode == 0) mode = 1;
        else begin mode = 2; exp_listo++; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".op_a"}, int'(op_a), val(qa));
    check({tag, ".op_b"}, int'(op_b), val(qb));
    check({tag, ".display"}, int'(display), mode == 0 ? val(qa) : val(qb));
    check({tag, ".n_dig"}, int'(n_dig), mode == 0 ? qa.size() : qb.size());
    check({tag, ".sel_b"}, int'(sel_b), int'(mode != 0));
    check({tag, ".done"}, int'(done), int'(mode == 2));
    check({tag, ".listo_cnt"}, listo_cnt, exp_listo);
  endtask

  task automatic press(input int k, input int hold);
    @(negedge clk);
    code = 4'(k);
    valido = 1'b1;
    repeat (hold) @(negedge clk);
    valido = 1'b0;
    repeat (3) @(negedge clk);
    model_key(k);
  endtask

  task automatic keys(input string tag, input int seq[$]);
    foreach (seq[i]) press(seq[i], 2);
    check_all(tag);
  endtask

  task automatic reset_model();
    qa.delete(); qb.delete(); mode = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    @(negedge clk);
    // first event latency: visible after the second rising edge
    code = 4'd1;
    valido = 1'b1;
    @(negedge clk);
    check("lat1.n_dig", int'(n_dig), 0);
    @(negedge clk);
    check("lat2.n_dig", int'(n_dig), 1);
    valido = 1'b0;
    repeat (3) @(negedge clk);
    model_key(1);
    press(12, 1);
    check_all("clear");
    keys("r030", '{1, 2, 3, 15, 4, 5, 15});
    check("r030.op_a", int'(op_a), 'h123);
    check("r030.op_b", int'(op_b), 'h045);
    check("r030.listo", listo_cnt, 1);
    keys("r034a", '{3});
    keys("r034b", '{12});
    keys("r031", '{9, 8, 7, 6});
    check("r031.op_a", int'(op_a), 'h987);
    keys("r032", '{12, 5, 6, 13, 15, 15});
    check("r032.op_a", int'(op_a), 'h005);
    check("r032.sel_b", int'(sel_b), 1);
    keys("done_ign", '{7, 15, 10, 11, 13, 14, 15});
    press(12, 1);
    press(7, 50);
    check_all("r033");
    check("r033.op_a", int'(op_a), 'h007);
    keys("bs_empty", '{13, 13, 14, 15});
    // mid-entry reset with valido held across the release
    keys("r035pre", '{12, 1, 2});
    @(negedge clk);
    code = 4'd4;
    valido = 1'b1;
    #2 rst = 1'b0;
    #1 reset_model();
    check_all("r035async");
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_all("r035held");
    valido = 1'b0;
    repeat (2) @(negedge clk);
    press(4, 3);
    check_all("r035after");
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 20);
      if (k > 15) k = 15;
      press(k, $urandom_range(1, 6));
      if (i % 10 == 9) check_all("rand");
    end
    check_all("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/module_control_entrada.md
MODULE_CONTROL_ENTRADA -- requirements
Module: module_control_entrada

Interface
REQ-001 SHALL have parameter N_DIGITS, default 3, meaning the maximum number of BCD digits per operand (legal range 1..4).
REQ-002 SHALL have port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port code  input  4  key code from the keypad scanner: 0x0-0x9 digits, 0xA-0xD letters A-D, 0xE '*', 0xF '#'.
REQ-005 SHALL have port valido  input  1  high while the scanner reports a valid pressed key; it may stay high for many cycles.
REQ-006 SHALL have port op_a  output  4*N_DIGITS  first operand in BCD, right-aligned.
REQ-007 SHALL have port op_b  output  4*N_DIGITS  second operand in BCD, right-aligned.
REQ-008 SHALL have port display  output  4*N_DIGITS  operand currently being edited (op_a in ENTRY_A, op_b in ENTRY_B and DONE).
REQ-009 SHALL have port n_dig  output  3  digit count of the operand being edited.
REQ-010 SHALL have port sel_b  output  1  high when the operand being edited is op_b.
REQ-011 SHALL have port listo  output  1  one-cycle pulse on entry to DONE.
REQ-012 SHALL have port done  output  1  high while in DONE.

Function
REQ-013 SHALL accept a key event only on the cycle following a 0->1 transition of registered valido; a held valido SHALL produce exactly one event.
REQ-014 SHALL implement states ENTRY_A, ENTRY_B and DONE.
REQ-015 Digit in ENTRY_A or ENTRY_B with n_dig < N_DIGITS: operand <= {operand[4*N_DIGITS-5:0], code}, n_dig+1; with n_dig == N_DIGITS, ignored.
REQ-016 'D' (backspace): operand <= operand >> 4 and n_dig-1; ignored when n_dig == 0.
REQ-017 '*': operand being edited <= 0 and n_dig <= 0; state unchanged.
REQ-018 '#' in ENTRY_A with n_dig > 0: go to ENTRY_B and set n_dig <= 0; ignored when n_dig == 0.
REQ-019 '#' in ENTRY_B with n_dig > 0: go to DONE and pulse listo for exactly 1 cycle; ignored when n_dig == 0.
REQ-020 'C' in any state: op_a, op_b and n_dig <= 0; go to ENTRY_A.
REQ-021 'A', 'B', and '#', '*', 'D' in DONE are ignored.
REQ-022 Digit in DONE: clear op_a and op_b, go to ENTRY_A, and load that digit as op_a = digit with n_dig = 1, all in one event.
REQ-023 Outputs SHALL be registered; each accepted event SHALL be reflected on the outputs 2 cycles after the valido rising edge.
REQ-024 op_a SHALL hold its value unchanged throughout ENTRY_B and DONE.

Reset
REQ-025 On rst low, asynchronously: state = ENTRY_A, op_a = op_b = display = 0, n_dig = 0, sel_b = 0, listo = 0, done = 0, valido history = 0.
REQ-026 After rst release, a valido already high SHALL NOT count as an event until it has been seen low.
REQ-027 Reset asserted mid-entry SHALL discard the partial operand, with no listo pulse.

Structure
REQ-028 The shared package pkg_teclado SHALL hold the state enum (ENTRY_A, ENTRY_B, DONE) and the key-code constants (KEY_STAR = 4'hE, KEY_HASH = 4'hF, KEY_C = 4'hC, KEY_D = 4'hD).
REQ-029 Rising-edge detection of valido SHALL be the sub-module module_detector_flanco (clk, rst, in, pulse).

Verification
REQ-030 Keys 1, 2, 3, #, 4, 5, # with N_DIGITS = 3 -> op_a = 0x123, op_b = 0x045, one listo pulse, done = 1.
REQ-031 Keys 9, 8, 7, 6 -> op_a = 0x987 and n_dig = 3; the fourth digit is ignored.
REQ-032 Keys 5, 6, D, then '#' with an empty ENTRY_B -> op_a = 0x005; '#' in ENTRY_B with n_dig = 0 leaves the state at ENTRY_B.
REQ-033 valido held high for 50 cycles with code = 7 -> exactly one digit accepted, op_a = 0x007.
REQ-034 In DONE, press 3 -> state ENTRY_A, op_a = 0x003, op_b = 0, done = 0; then press C -> all outputs 0.
REQ-035 rst low after keys 1, 2 -> all outputs 0 immediately; with valido held high across the release, no event until valido falls and rises again.
